// File: rtl/modmul_pm_serial.sv
// Digit-serial modular multiplier mod P = 2^WIDTH - C, consuming DIGIT bits of b per cycle (MSB first).
// Latency NDIG+2 cycles from accept to out_valid; one operation in flight, result held until out_ready.
module modmul_pm_serial #(
  parameter int WIDTH = 255,
  parameter int C     = 19,
  parameter int DIGIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int TW   = WIDTH + DIGIT + 2;
  localparam logic [WIDTH:0]  PMOD = {1'b1, {WIDTH{1'b0}}} - (WIDTH+1)'(C);
  localparam logic [CW-1:0]   LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   acc;
  logic [CW-1:0]    cnt;
  logic             fin_ph;
  logic             accept;

  logic [DIGIT-1:0]       digit;
  logic [WIDTH+DIGIT-1:0] prod;
  logic [TW-1:0]          t;
  logic [WIDTH:0]         fold_run;
  logic [WIDTH:0]         fold_fin;
  logic [WIDTH-1:0]       reduced;

  assign accept = in_valid && in_ready;

  // fold maps the bits above 2^WIDTH back in as multiples of C, keeping acc below 2^(WIDTH+1)
  always_comb begin
    digit    = b_q[WIDTH-1 -: DIGIT];
    prod     = {{DIGIT{1'b0}}, a_q} * {{WIDTH{1'b0}}, digit};
    t        = TW'({acc, {DIGIT{1'b0}}}) + TW'(prod);
    fold_run = (WIDTH+1)'(t[WIDTH-1:0]) + (WIDTH+1)'(t[TW-1:WIDTH]) * (WIDTH+1)'(C);
    fold_fin = {1'b0, acc[WIDTH-1:0]} + (acc[WIDTH] ? (WIDTH+1)'(C) : '0);
    reduced  = (acc >= PMOD) ? WIDTH'(acc - PMOD) : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)       state_nxt = RUN;
      RUN:     if (cnt == LAST)  state_nxt = FINAL;
      FINAL:   if (fin_ph)       state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == DONE);
  end

  // in_ready is registered so it stays low through reset and the first edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      fin_ph   <= 1'b0;
      out      <= '0;
    end else begin
      in_ready <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= in1;
            b_q    <= op ? in1 : in2;
            acc    <= '0;
            cnt    <= '0;
            fin_ph <= 1'b0;
          end
        end
        RUN: begin
          acc <= fold_run;
          b_q <= b_q << DIGIT;
          cnt <= cnt + 1'b1;
        end
        FINAL: begin
          if (!fin_ph) begin
            acc    <= fold_fin;
            fin_ph <= 1'b1;
          end else begin
            out <= reduced;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
